// File: rtl/mem_sequencer_if.sv
// ----------------------------------------------------------------------------
// mem_sequencer_if
//   Request/acknowledge bus between the memory sequencer and a
//   variable-latency RAM.
//
//   Signals
//     mem_req    sequencer -> RAM   request, held high until ack or abort
//     mem_we     sequencer -> RAM   1 = write request, 0 = read request
//     mem_addr   sequencer -> RAM   word address (the MAR contents)
//     mem_wdata  sequencer -> RAM   write data (the MDR contents)
//     mem_rdata  RAM -> sequencer   read data, valid together with mem_ack
//     mem_ack    RAM -> sequencer   one-cycle completion pulse
//
//   Modports
//     master  the sequencer side (drives the request)
//     slave   the RAM side (answers the request)
// ----------------------------------------------------------------------------
interface mem_sequencer_if #(
    parameter int ADDR_W = 9
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_sequencer.sv
// ----------------------------------------------------------------------------
// mem_sequencer
//   Memory-side stage of the CPU datapath. Holds the MAR and MDR and runs a
//   req/ack handshake to a variable-latency RAM. While an access is pending,
//   stall tells the control unit to hold its state. An access that is not
//   acknowledged within TIMEOUT cycles is aborted and flagged in the sticky
//   mem_fault bit.
//
//   Ports
//     clock         system clock, all state on the rising edge
//     reset_n       synchronous active-low reset
//     clear         synchronous clear of mem_fault
//     MARin         load MAR from BusMuxOut (idle only)
//     MDRin         load MDR from bus (idle, no access) or from RAM on read
//     memRead       1 = read, 0 = write; qualified by ramEnable
//     ramEnable     start an access (sampled in idle only)
//     BusMuxOut     CPU bus
//     BusMuxIn_MDR  MDR contents towards the bus mux
//     stall         1 = control unit must hold its state
//     mem_fault     sticky timeout flag
//     mem           RAM request bus (master side)
// ----------------------------------------------------------------------------
module mem_sequencer #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  MARin,
    input  logic                  MDRin,
    input  logic                  memRead,
    input  logic                  ramEnable,
    input  logic [31:0]           BusMuxOut,
    output logic [31:0]           BusMuxIn_MDR,
    output logic                  stall,
    output logic                  mem_fault,
    mem_sequencer_if.master       mem
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  mar_q, mar_d;
    logic [31:0]        mdr_q, mdr_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic               fault_q, fault_d;
    logic               waiting_s;
    logic               timeout_s;

    // Bus bits above the RAM address width are deliberately discarded by MAR.
    logic               unused_bus_s;
    assign unused_bus_s = ^BusMuxOut[31:ADDR_W];

    // State, counter, MAR/MDR, request and fault registers with sync reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mar_q   <= '0;
            mdr_q   <= 32'h0000_0000;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            req_q   <= req_d;
            we_q    <= we_d;
            fault_q <= fault_d;
        end
    end

    // Next-state, counter, MAR/MDR load, request and fault logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mar_d     = mar_q;
        mdr_d     = mdr_q;
        fault_d   = fault_q;
        waiting_s = 1'b0;
        timeout_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // MAR/MDR only follow the bus here, so the address and write
                // data stay frozen for the whole request.
                if (MARin) begin
                    mar_d = BusMuxOut[ADDR_W-1:0];
                end else begin
                    mar_d = mar_q;
                end
                if (MDRin && !ramEnable) begin
                    mdr_d = BusMuxOut;
                end else begin
                    mdr_d = mdr_q;
                end
                if (ramEnable) begin
                    state_d = memRead ? ST_RD_WAIT : ST_WR_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_WAIT, ST_WR_WAIT: begin
                waiting_s = 1'b1;
                cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (mem.mem_ack) begin
                    // An ack on the timeout cycle still completes normally.
                    state_d = ST_DONE;
                    if ((state_q == ST_RD_WAIT) && MDRin) begin
                        mdr_d = mem.mem_rdata;
                    end else begin
                        mdr_d = mdr_q;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_DONE;
                    timeout_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A timeout on the same edge as clear leaves the fault set.
        if (timeout_s) begin
            fault_d = 1'b1;
        end else if (clear) begin
            fault_d = 1'b0;
        end else begin
            fault_d = fault_q;
        end

        // Request lines are registered copies of the upcoming wait state.
        req_d = (state_d == ST_RD_WAIT) || (state_d == ST_WR_WAIT);
        we_d  = (state_d == ST_WR_WAIT);
    end

    // Stall rises combinationally in idle so the control unit never slips
    // past its access state before the request has been accepted.
    assign stall = (state_q == ST_IDLE && ramEnable) || waiting_s;

    assign BusMuxIn_MDR  = mdr_q;
    assign mem_fault     = fault_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = mar_q;
    assign mem.mem_wdata = mdr_q;

endmodule
